// File: rtl/nov_pattern_tx_1101.sv
// nov_pattern_tx_1101: Moore FSM that serialises reps copies of PATTERN (MSB first) on x,
// with gap filler bits between copies.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   start : transfer request, sampled only in IDLE
//   reps  : number of pattern copies, captured with start (0 = ignored)
//   gap   : filler bits between copies, captured with start
//   abort : synchronous cancel while sending or in a gap
//   x     : serial line
//   valid : x carries pattern or filler
//   busy  : first bit through the DONE cycle
//   done  : one-cycle pulse after the last pattern bit
module nov_pattern_tx_1101 #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter logic               FILL    = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    input  logic             abort,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(PAT_LEN - 1);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [CNT_W-1:0] rep, rep_n, gap_q, gap_n, gcnt, gcnt_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            rep   <= '0;
            gap_q <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            rep   <= rep_n;
            gap_q <= gap_n;
            gcnt  <= gcnt_n;
        end
    end
    // rep holds the copies still to send including the current one, so it stops at 1.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        rep_n   = rep;
        gap_n   = gap_q;
        gcnt_n  = gcnt;
        case (state)
            IDLE: if (start && reps != '0) begin
                state_n = SEND;
                idx_n   = LAST;
                rep_n   = reps;
                gap_n   = gap;
            end
            SEND: if (abort) state_n = IDLE;
                else if (idx != '0) idx_n = idx - IW'(1);
                else if (rep == CNT_W'(1)) state_n = DONE;
                else begin
                    rep_n = rep - CNT_W'(1);
                    if (gap_q == '0) idx_n = LAST;
                    else begin
                        state_n = GAP;
                        gcnt_n  = gap_q;
                    end
                end
            GAP: if (abort) state_n = IDLE;
                else if (gcnt == CNT_W'(1)) begin
                    state_n = SEND;
                    idx_n   = LAST;
                end else gcnt_n = gcnt - CNT_W'(1);
            default: state_n = IDLE;
        endcase
    end
    assign x     = (state == SEND) ? PATTERN[idx] : (state == GAP) ? FILL : 1'b0;
    assign valid = (state == SEND) || (state == GAP);
    assign busy  = state != IDLE;
    assign done  = state == DONE;
endmodule

// File: tb/tb_nov_pattern_tx_1101.sv
// tb_nov_pattern_tx_1101: directed bench for the 1101 pattern transmitter.
module tb_nov_pattern_tx_1101;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] reps = '0;
    logic [7:0] gap = '0;
    logic       abort = 1'b0;
    logic       x, valid, busy, done;
    int checks = 0;
    int errors = 0;
    logic xs [0:63];
    logic vs [0:63];
    logic bs [0:63];
    logic ds [0:63];

    nov_pattern_tx_1101 dut (
        .clk(clk), .rst(rst), .start(start), .reps(reps), .gap(gap),
        .abort(abort), .x(x), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic kick(input logic [7:0] r, input logic [7:0] g);
        @(negedge clk);
        start = 1'b1;
        reps  = r;
        gap   = g;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            xs[i] = x;
            vs[i] = valid;
            bs[i] = busy;
            ds[i] = done;
            if (i == 0) start = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {x, valid, busy, done});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 0000", {x, valid, busy, done});
        end
    endtask

    task automatic test_single;
        int nb = 0;
        kick(8'd1, 8'd0);
        capture(7);
        checks++;
        if ({xs[0], xs[1], xs[2], xs[3]} !== 4'b1101) begin
            errors++;
            $display("FAIL single_x: got %b expected 1101", {xs[0], xs[1], xs[2], xs[3]});
        end
        checks++;
        if ({vs[0], vs[1], vs[2], vs[3], vs[4]} !== 5'b11110) begin
            errors++;
            $display("FAIL single_valid: got %b expected 11110", {vs[0], vs[1], vs[2], vs[3], vs[4]});
        end
        checks++;
        if ({ds[3], ds[4], ds[5]} !== 3'b010) begin
            errors++;
            $display("FAIL single_done: got %b expected 010", {ds[3], ds[4], ds[5]});
        end
        for (int i = 0; i < 7; i++) nb += int'(bs[i]);
        checks++;
        if (nb != 5 || bs[5] !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %0d busy cycles expected 5", nb);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] s;
        logic [3:0]  sh = '0;
        int hits = 0;
        kick(8'd3, 8'd0);
        capture(14);
        for (int i = 0; i < 12; i++) begin
            s[11-i] = xs[i];
            sh = {sh[2:0], xs[i]};
            if (sh == 4'b1101) begin
                hits++;
                sh = '0;
            end
        end
        checks++;
        if (s !== 12'b110111011101) begin
            errors++;
            $display("FAIL b2b_x: got %b expected 110111011101", s);
        end
        checks++;
        if (hits != 3) begin
            errors++;
            $display("FAIL b2b_detect: got %0d matches expected 3", hits);
        end
        checks++;
        if ({ds[11], ds[12], ds[13], vs[11], vs[12]} !== 5'b01010) begin
            errors++;
            $display("FAIL b2b_done: got %b expected 01010", {ds[11], ds[12], ds[13], vs[11], vs[12]});
        end
    endtask

    task automatic test_gap;
        logic [9:0] s;
        int nv = 0;
        kick(8'd2, 8'd2);
        capture(12);
        for (int i = 0; i < 10; i++) s[9-i] = xs[i];
        for (int i = 0; i < 12; i++) nv += int'(vs[i]);
        checks++;
        if (s !== 10'b1101001101) begin
            errors++;
            $display("FAIL gap_x: got %b expected 1101001101", s);
        end
        checks++;
        if (nv != 10 || vs[10] !== 1'b0) begin
            errors++;
            $display("FAIL gap_valid: got %0d valid cycles expected 10", nv);
        end
        checks++;
        if ({ds[9], ds[10], bs[11]} !== 3'b010) begin
            errors++;
            $display("FAIL gap_done: got %b expected 010", {ds[9], ds[10], bs[11]});
        end
    endtask

    task automatic test_zero_reps;
        logic any = 1'b0;
        kick(8'd0, 8'd5);
        capture(4);
        for (int i = 0; i < 4; i++) any |= xs[i] | vs[i] | bs[i] | ds[i];
        checks++;
        if (any !== 1'b0) begin
            errors++;
            $display("FAIL zero_reps: got activity %b expected 0", any);
        end
    endtask

    task automatic test_start_while_busy;
        kick(8'd1, 8'd0);
        capture(1);
        start = 1'b1;
        reps  = 8'd5;
        gap   = 8'd3;
        capture(6);
        checks++;
        if ({ds[2], ds[3], bs[4]} !== 3'b010) begin
            errors++;
            $display("FAIL start_busy_ignored: got %b expected 010", {ds[2], ds[3], bs[4]});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_abort;
        logic seen_done = 1'b0;
        kick(8'd4, 8'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            seen_done |= done;
        end
        checks++;
        if ({x, valid} !== 2'b11) begin
            errors++;
            $display("FAIL abort_sixth_bit: got %b expected 11", {x, valid});
        end
        abort = 1'b1;
        @(negedge clk);
        seen_done |= done;
        checks++;
        if ({x, valid, busy, seen_done} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_stop: got %b expected 0000", {x, valid, busy, seen_done});
        end
        abort = 1'b0;
        start = 1'b1;
        reps  = 8'd1;
        gap   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({x, valid, busy} !== 3'b111) begin
            errors++;
            $display("FAIL abort_restart: got %b expected 111", {x, valid, busy});
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_done: got %b expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        kick(8'd2, 8'd3);
        capture(6);
        checks++;
        if ({x, valid, busy} !== 3'b011) begin
            errors++;
            $display("FAIL areset_in_gap: got %b expected 011", {x, valid, busy});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL areset_immediate: got %b expected 0000", {x, valid, busy, done});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({valid, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL areset_stays_idle: cycle %0d got %b expected 000", i, {valid, busy, done});
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_gap;
        test_zero_reps;
        test_start_while_busy;
        test_abort;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
